// File: rtl/phoeniX_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, state encodings
// for the loader FSM and the UART receiver, and an image-size helper.
package phoeniX_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Largest image, in 32-bit words, that fits a byte-addressed memory.
  function automatic int max_words(input int address_width);
    return (1 << address_width) / 4;
  endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. rx is synchronised, a falling edge starts bit timing,
// and bits are sampled near their middle. A good stop bit produces a one-cycle
// byte_valid pulse with byte_data; a low stop bit produces a one-cycle
// frame_err pulse and the byte is dropped.
module uart_receiver
  import phoeniX_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte_data;
  logic          r_byte_valid;
  logic          r_frame_err;

  // Synchroniser, bit timing and shift register; pulses are cleared each cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          // Count starts at 1 to absorb the cycle spent detecting the edge.
          r_cnt <= CW'(1);
          if (r_rx_prev && !r_rx_sync) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt >= HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over UART
// (A5, LEN_LO, LEN_HI, N*4 data bytes, CHK) and writes it word by word into
// instruction memory, holding the core in reset until a valid image is loaded.
//
// Byte handshake: byte_valid and frame_err from the receiver are single-cycle
// pulses with no back-pressure; the loader consumes every pulse in the cycle
// it occurs, so there is no ready signal.
module uart_program_loader
  import phoeniX_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 87,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     rx,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_write_data,
  output logic                     core_reset,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_error
);

  localparam logic [16:0] MAX_WORDS = 17'(max_words(ADDRESS_WIDTH));

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic [15:0] w_len;

  loader_state_t            r_state;
  logic [7:0]               r_sum;
  logic [15:0]              r_len;
  logic [15:0]              r_word_idx;
  logic [1:0]               r_byte_idx;
  logic [23:0]              r_asm;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [31:0]              r_mem_data;
  logic                     r_core_reset;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;

  uart_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK       (CLK),
    .reset     (reset),
    .rx        (rx),
    .byte_data (w_byte),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  // Word count as it becomes known on the LEN_HI byte.
  assign w_len = {w_byte, r_len[7:0]};

  // Loader FSM: frame parsing, word assembly, write strobe and status flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sum        <= '0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_frame_err && (r_state inside {LEN_LO, LEN_HI, DATA, CHECK})) begin
        r_state <= ERROR;
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_byte_valid) begin
        case (r_state)
          IDLE, ERROR: begin
            if (w_byte == SYNC_BYTE) begin
              r_sum      <= '0;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_busy     <= 1'b1;
              r_error    <= 1'b0;
              r_state    <= LEN_LO;
            end
          end
          LEN_LO: begin
            r_len[7:0] <= w_byte;
            r_sum      <= r_sum + w_byte;
            r_state    <= LEN_HI;
          end
          LEN_HI: begin
            r_len[15:8] <= w_byte;
            r_sum       <= r_sum + w_byte;
            if ({1'b0, w_len} > MAX_WORDS) begin
              r_state <= ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_len == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
          DATA: begin
            r_sum      <= r_sum + w_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= w_byte;
              2'd1: r_asm[15:8]  <= w_byte;
              2'd2: r_asm[23:16] <= w_byte;
              default: begin
                // Completed word moves to the output register so the next
                // word can start assembling while the strobe is out.
                r_mem_we   <= 1'b1;
                r_mem_data <= {w_byte, r_asm};
                r_mem_addr <= {r_word_idx[ADDRESS_WIDTH-3:0], 2'b00};
                r_word_idx <= r_word_idx + 16'd1;
                if (r_word_idx == r_len - 16'd1) r_state <= CHECK;
              end
            endcase
          end
          CHECK: begin
            r_busy <= 1'b0;
            if (w_byte == r_sum) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_write_enable = r_mem_we;
  assign mem_address      = r_mem_addr;
  assign mem_write_data   = r_mem_data;
  assign core_reset       = r_core_reset;
  assign busy             = r_busy;
  assign load_done        = r_done;
  assign load_error       = r_error;

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader: drives UART frames, models the expected
// memory writes from the frame contents, and checks status flags.
module tb_uart_program_loader;

  localparam int CPB = 4;
  localparam int AW  = 12;

  // Clock / reset
  logic CLK = 1'b0;
  logic reset;
  logic rx;
  always #5 CLK = ~CLK;

  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          core_reset;
  logic          busy;
  logic          load_done;
  logic          load_error;

  uart_program_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .CLK             (CLK),
    .reset           (reset),
    .rx              (rx),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .core_reset      (core_reset),
    .busy            (busy),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: {address, data} of each write
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] obs_q[$];
  logic [31:0]    tx_words[$];
  int             bv_count  = 0;
  int             double_we = 0;
  logic           prev_we   = 1'b0;

  // Monitor: collect write strobes, catch multi-cycle strobes, count bytes
  always @(negedge CLK) begin
    if (mem_write_enable) obs_q.push_back({mem_address, mem_write_data});
    if (mem_write_enable && prev_we) double_we++;
    prev_we = mem_write_enable;
    if (dut.u_rx.byte_valid) bv_count++;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    @(negedge CLK);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Sends A5, N, the words in tx_words, and checksum XOR chk_xor; queues the
  // writes the frame must produce.
  task automatic send_frame(input logic [7:0] chk_xor, input int gap);
    logic [15:0] n;
    logic [7:0]  s;
    logic [31:0] w;
    n = 16'(tx_words.size());
    s = n[7:0] + n[15:8];
    send_byte(8'hA5, 1'b1, gap);
    send_byte(n[7:0], 1'b1, gap);
    send_byte(n[15:8], 1'b1, gap);
    for (int i = 0; i < tx_words.size(); i++) begin
      w = tx_words[i];
      for (int b = 0; b < 4; b++) begin
        s = s + w[8*b +: 8];
        send_byte(w[8*b +: 8], 1'b1, gap);
      end
      exp_q.push_back({AW'(i * 4), w});
    end
    send_byte(s ^ chk_xor, 1'b1, gap);
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [AW+37:0] got;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    got = {mem_write_enable, mem_address, mem_write_data, core_reset, busy, load_done, load_error};
    tests_run++;
    if (got !== {1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h", got, {1'b0, AW'(0), 32'h0, 1'b1, 3'b000});
    end
  endtask

  task automatic test_known_frame();
    do_reset();
    tx_words = '{32'h00000013, 32'h00100093};
    send_frame(8'h00, 2);
    tests_run++;
    if (obs_q.size() != 2) begin
      tests_failed++;
      $display("FAIL known_write_count: got %0d expected 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL known_write_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL known_status: got %b expected 1000", {load_done, load_error, core_reset, busy});
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    tx_words = '{32'h00000013, 32'h00100093};
    send_frame(8'h01, 2);
    tests_run++;
    if (obs_q != exp_q) begin
      tests_failed++;
      $display("FAIL badchk_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL badchk_status: got %b expected 0110", {load_done, load_error, core_reset, busy});
    end
    obs_q.delete();
    exp_q.delete();
    send_frame(8'h00, 1);
    tests_run++;
    if (obs_q != exp_q) begin
      tests_failed++;
      $display("FAIL recover_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL recover_status: got %b expected 1000", {load_done, load_error, core_reset, busy});
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hA5, 1'b1, 2);
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h04, 1'b1, 2);
    repeat (8) @(negedge CLK);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL oversize_writes: got %0d expected 0", obs_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL oversize_status: got %b expected 0110", {load_done, load_error, core_reset, busy});
    end
  endtask

  task automatic test_garbage_empty();
    logic [7:0] seq [7];
    do_reset();
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) send_byte(seq[i], 1'b1, 1);
    repeat (8) @(negedge CLK);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL empty_writes: got %0d expected 0", obs_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL empty_status: got %b expected 1000", {load_done, load_error, core_reset, busy});
    end
  endtask

  task automatic test_frame_err();
    int bv_before;
    do_reset();
    send_byte(8'hA5, 1'b1, 2);
    send_byte(8'h02, 1'b1, 2);
    send_byte(8'h00, 1'b1, 2);
    send_byte(8'h11, 1'b1, 2);
    send_byte(8'h22, 1'b1, 2);
    send_byte(8'h33, 1'b0, 2);
    send_byte(8'h44, 1'b1, 2);
    repeat (8) @(negedge CLK);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL framerr_writes: got %0d expected 0", obs_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL framerr_status: got %b expected 0110", {load_done, load_error, core_reset, busy});
    end
    // One-cycle low glitch on an idle line
    do_reset();
    bv_before = bv_count;
    rx = 1'b0;
    @(negedge CLK);
    rx = 1'b1;
    repeat (60) @(negedge CLK);
    tests_run++;
    if (bv_count != bv_before || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got %0d bytes busy=%b expected 0 bytes busy=0", bv_count - bv_before, busy);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [AW+37:0] got;
    do_reset();
    send_byte(8'hA5, 1'b1, 2);
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h00, 1'b1, 2);
    send_byte(8'hDE, 1'b1, 2);
    send_byte(8'hAD, 1'b1, 2);
    repeat (4) @(negedge CLK);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL middata_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    got = {mem_write_enable, mem_address, mem_write_data, core_reset, busy, load_done, load_error};
    tests_run++;
    if (got !== {1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL middata_reset_values: got %h expected %h", got, {1'b0, AW'(0), 32'h0, 1'b1, 3'b000});
    end
    obs_q.delete();
    exp_q.delete();
    tx_words = '{$urandom, $urandom};
    send_frame(8'h00, 2);
    tests_run++;
    if (obs_q != exp_q) begin
      tests_failed++;
      $display("FAIL middata_reload_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if ({load_done, load_error, core_reset, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL middata_reload_status: got %b expected 1000", {load_done, load_error, core_reset, busy});
    end
  endtask

  task automatic test_random_frames();
    int          n;
    logic        good;
    logic [7:0]  x;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n    = $urandom_range(1, 5);
      good = 1'($urandom_range(0, 1));
      x    = good ? 8'h00 : 8'($urandom_range(1, 255));
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      send_frame(x, $urandom_range(0, 3));
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL rand%0d_count: got %0d expected %0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rand%0d_write%0d: got %h expected %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      tests_run++;
      if ({load_done, load_error, core_reset, busy} !== {good, !good, !good, 1'b0}) begin
        tests_failed++;
        $display("FAIL rand%0d_status: got %b expected %b", t, {load_done, load_error, core_reset, busy}, {good, !good, !good, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_words = '{$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h00, 0);
    tests_run++;
    if (obs_q != exp_q) begin
      tests_failed++;
      $display("FAIL b2b_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (load_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done: got %b expected 1", load_done);
    end
    tests_run++;
    if (double_we != 0) begin
      tests_failed++;
      $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", double_we);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_known_frame();
    test_bad_checksum();
    test_oversize();
    test_garbage_empty();
    test_frame_err();
    test_reset_mid_data();
    test_random_frames();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time block upstream of the phoeniX core's instruction memory. It replaces the simulation-only hex preload with a serial download path.
- Receives a framed program image over an 8N1 UART line and writes it word by word into instruction memory.
- Holds the core in reset until a complete, checksum-valid image has been written.

Parameters:
- CLKS_PER_BIT, 87, CLK cycles per UART bit (minimum 4).
- ADDRESS_WIDTH, 12, byte-address width of instruction memory. Maximum image size is 2**ADDRESS_WIDTH/4 words.

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART receive line; idles high.
- mem_write_enable  output  1  one-cycle write strobe to instruction memory.
- mem_address  output  ADDRESS_WIDTH  byte address; always word-aligned.
- mem_write_data  output  32  little-endian assembled word.
- core_reset  output  1  reset to core; high until load succeeds.
- busy  output  1  high while a frame is in progress.
- load_done  output  1  sticky success flag.
- load_error  output  1  sticky failure flag.

Behaviour:
Interface rules:
- One clock (CLK); reset is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset values: mem_write_enable=0, mem_address=0, mem_write_data=0, core_reset=1, busy=0, load_done=0, load_error=0. The receiver returns to idle and the running sum and counters clear.
- Reset mid-frame discards the partial frame. Words already written stay in memory.

UART receiver:
- rx passes through a 2-flop synchronizer.
- A falling edge starts bit timing. The start bit is re-checked at CLKS_PER_BIT/2; if rx is high there, it is a glitch and the receiver returns to idle.
- Data bits are sampled at the middle of each bit, LSB first.
- If the stop bit samples 1, byte_valid pulses for one cycle with the byte.
- If the stop bit samples 0, the byte is dropped and frame_err pulses for one cycle.
- The receiver is ready for a new start bit in the cycle after the stop-bit sample.

Frame format, all bytes:
- 0xA5 sync.
- LEN_LO, LEN_HI: 16-bit word count N.
- N×4 data bytes, little-endian per word.
- CHK = (LEN_LO + LEN_HI + all data bytes) mod 256.

Loader FSM:
- IDLE: non-0xA5 bytes are ignored. On 0xA5, clear sum, word index and byte index; set busy=1; go to LEN_LO.
- LEN_LO → LEN_HI: each length byte is added to the sum.
- After LEN_HI:
  - N > 2**ADDRESS_WIDTH/4 → ERROR.
  - N = 0 → CHECK.
  - Otherwise → DATA.
- DATA:
  - Each byte shifts into mem_write_data[8*byte_idx +: 8] and is added to the sum.
  - On the 4th byte: in the next cycle mem_write_enable=1 for exactly one cycle, mem_address = word_idx*4, data stable. Then word_idx increments.
  - After word N-1 → CHECK.
- CHECK:
  - Byte == sum → DONE.
  - Byte != sum → ERROR.
- DONE: load_done=1, busy=0, core_reset=0 from the cycle after the CHK byte's byte_valid. All rx traffic is ignored until reset.
- ERROR: load_error=1, busy=0, core_reset stays 1.
  - A subsequent 0xA5 clears load_error and restarts the frame (LEN_LO).
  - Other bytes are ignored.
- A frame_err pulse in any state other than IDLE/DONE → ERROR.
- A byte_valid arriving in the same cycle as a pending write is legal: the write strobe uses the held word while the new byte begins the next word. Words are double-buffered (assembly register and output register).
- Address arithmetic is unsigned ADDRESS_WIDTH bits. With N legal, mem_address never wraps.

Decomposition:
- Shared package phoeniX_loader_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - FSM state encoding: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - Receiver state encoding: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- One sub-module: uart_receiver (CLK, reset, rx → byte_data[7:0], byte_valid, frame_err), parameterised by CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4, ADDRESS_WIDTH=12):
- Frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | CHK=0xB8 → two strobes:
  - addr 0x000 data 0x00000013.
  - addr 0x004 data 0x00100093.
  - Then load_done=1, core_reset=0, load_error=0.
- Same frame with CHK=0xB9 → both writes occur, load_error=1, core_reset=1. A correct frame resent afterward → load_done=1, load_error=0.
- A5 01 04 (N=1025 > 1024) → no write strobe, load_error=1.
- Garbage bytes 00 FF 5A before sync, then A5 00 00 CHK=00 → no writes, load_done=1 after CHK.
- Stop bit forced low on the 3rd data byte → frame_err, load_error=1, no strobe for that word. A 1-cycle low glitch on an idle rx → no byte_valid.
- reset asserted mid-DATA after 2 of 4 bytes → all outputs return to reset values; a fresh full frame then loads correctly from address 0.
